// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one combinational ALU between two requesters.
// Registers the winning operation and returns the result over a valid/ready channel.
module alu_share_arbiter #(
    parameter int WIDTH = 32,
    parameter int OPW   = 5,
    parameter int CNTW  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    input  logic [OPW-1:0]   req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [OPW-1:0]   req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             req1_ready,
    output logic [OPW-1:0]   alu_op,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_res,
    input  logic             alu_flag,
    output logic             rsp_valid,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_res,
    output logic             rsp_flag,
    input  logic             rsp_ready,
    output logic             busy,
    output logic [CNTW-1:0]  op_count
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_RESP
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic             r_last;
    logic             r_owner;
    logic [OPW-1:0]   r_alu_op;
    logic [WIDTH-1:0] r_alu_a;
    logic [WIDTH-1:0] r_alu_b;
    logic             r_rsp_valid;
    logic             r_rsp_id;
    logic [WIDTH-1:0] r_rsp_res;
    logic             r_rsp_flag;
    logic [CNTW-1:0]  r_cnt;

    logic             w_retire;
    logic             w_window;
    logic             w_win0;
    logic             w_win1;
    logic             w_acc;
    logic             w_sel;

    // The response retires in the same cycle a new operation may be taken.
    assign w_retire = (r_state == S_RESP) & rsp_ready;
    assign w_window = (r_state == S_IDLE) | w_retire;

    // On a tie the port that did not win last time goes first.
    assign w_win0 = req0_valid & (~req1_valid | r_last);
    assign w_win1 = req1_valid & (~req0_valid | ~r_last);

    assign req0_ready = w_window & w_win0;
    assign req1_ready = w_window & w_win1;
    assign w_acc      = req0_ready | req1_ready;
    assign w_sel      = req1_ready;

    assign alu_op    = r_alu_op;
    assign alu_a     = r_alu_a;
    assign alu_b     = r_alu_b;
    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_rsp_id;
    assign rsp_res   = r_rsp_res;
    assign rsp_flag  = r_rsp_flag;
    assign busy      = (r_state != S_IDLE);
    assign op_count  = r_cnt;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state: accept -> one ALU cycle -> hold response until taken.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_acc) begin
                    w_next = S_EXEC;
                end
            end
            S_EXEC: begin
                w_next = S_RESP;
            end
            S_RESP: begin
                if (rsp_ready) begin
                    w_next = w_acc ? S_EXEC : S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Latch the winning operation into the ALU input registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_alu_op <= '0;
            r_alu_a  <= '0;
            r_alu_b  <= '0;
            r_owner  <= 1'b0;
            r_last   <= 1'b1;
        end else if (w_acc) begin
            r_alu_op <= w_sel ? req1_op : req0_op;
            r_alu_a  <= w_sel ? req1_a  : req0_a;
            r_alu_b  <= w_sel ? req1_b  : req0_b;
            r_owner  <= w_sel;
            r_last   <= w_sel;
        end
    end

    // Capture ALU outputs after the operation has had one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rsp_res  <= '0;
            r_rsp_flag <= 1'b0;
            r_rsp_id   <= 1'b0;
        end else if (r_state == S_EXEC) begin
            r_rsp_res  <= alu_res;
            r_rsp_flag <= alu_flag;
            r_rsp_id   <= r_owner;
        end
    end

    // Valid rises after EXEC; drops only when retired with nothing queued.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rsp_valid <= 1'b0;
        end else if (r_state == S_EXEC) begin
            r_rsp_valid <= 1'b1;
        end else if (w_retire & ~w_acc) begin
            r_rsp_valid <= 1'b0;
        end
    end

    // Saturating count of retired responses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_retire && (r_cnt != '1)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: directed table, corner sequences, random traffic
// against a transaction-level reference model.
module tb_alu_share_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0_valid, req1_valid;
    logic [4:0]  req0_op, req1_op;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic        req0_ready, req1_ready;
    logic [4:0]  alu_op;
    logic [31:0] alu_a, alu_b, alu_res;
    logic        alu_flag;
    logic        rsp_valid, rsp_id, rsp_flag, rsp_ready;
    logic [31:0] rsp_res;
    logic        busy;
    logic [15:0] op_count;

    logic        s_r0, s_r1;
    logic [4:0]  s_alu_op;
    logic [31:0] s_alu_a, s_alu_b, s_alu_res;
    logic        s_alu_flag;
    logic        s_rsp_valid, s_rsp_id, s_rsp_flag, s_busy;
    logic [31:0] s_rsp_res;
    logic [1:0]  s_op_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_share_arbiter u_dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
        .alu_res(alu_res), .alu_flag(alu_flag),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id),
        .rsp_res(rsp_res), .rsp_flag(rsp_flag), .rsp_ready(rsp_ready),
        .busy(busy), .op_count(op_count)
    );

    alu_share_arbiter #(.CNTW(2)) u_sat (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b), .req0_ready(s_r0),
        .req1_valid(req1_valid), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b), .req1_ready(s_r1),
        .alu_op(s_alu_op), .alu_a(s_alu_a), .alu_b(s_alu_b),
        .alu_res(s_alu_res), .alu_flag(s_alu_flag),
        .rsp_valid(s_rsp_valid), .rsp_id(s_rsp_id),
        .rsp_res(s_rsp_res), .rsp_flag(s_rsp_flag), .rsp_ready(rsp_ready),
        .busy(s_busy), .op_count(s_op_count)
    );

    // Test ALU: ADD, SUB, EQ, LTU; everything else xor / parity-ish flag.
    function automatic logic [32:0] alu_fn(logic [4:0] op, logic [31:0] a,
                                           logic [31:0] b);
        logic [31:0] r;
        logic        f;
        case (op)
            5'b00000: r = a + b;
            5'b01000: r = a - b;
            default:  r = a ^ b;
        endcase
        case (op)
            5'b11000: f = (a == b);
            5'b11110: f = (a < b);
            default:  f = a[0] ^ b[0];
        endcase
        return {f, r};
    endfunction

    always_comb {alu_flag, alu_res} = alu_fn(alu_op, alu_a, alu_b);
    always_comb {s_alu_flag, s_alu_res} = alu_fn(s_alu_op, s_alu_a, s_alu_b);

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: at most one transaction in flight, aged in clock edges.
    typedef struct {
        bit          id;
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
    } txn_t;

    txn_t        m_q[$];
    int          m_age;
    bit          m_last;
    int          m_cnt;
    bit          m_rv;
    logic [4:0]  m_aop;
    logic [31:0] m_aa, m_ab;

    bit o_r0, o_r1;

    task automatic model_reset();
        m_q.delete();
        m_age  = 0;
        m_last = 1'b1;
        m_cnt  = 0;
        m_rv   = 1'b0;
        m_aop  = '0;
        m_aa   = '0;
        m_ab   = '0;
    endtask

    // One clock of stimulus: drive, check at negedge, advance model at posedge.
    task automatic cyc(input bit v0, input logic [4:0] op0, input logic [31:0] a0,
                       input logic [31:0] b0, input bit v1, input logic [4:0] op1,
                       input logic [31:0] a1, input logic [31:0] b1, input bit rr);
        bit          win, g0, g1, ret, acc;
        logic [32:0] e;
        txn_t        t;
        req0_valid = v0; req0_op = op0; req0_a = a0; req0_b = b0;
        req1_valid = v1; req1_op = op1; req1_a = a1; req1_b = b1;
        rsp_ready  = rr;
        @(negedge clk);
        win = (m_q.size() == 0) || (m_age >= 2 && rr);
        g0  = win && v0 && (!v1 || m_last);
        g1  = win && v1 && (!v0 || !m_last);
        chk("req0_ready", req0_ready, g0);
        chk("req1_ready", req1_ready, g1);
        chk("busy", busy, m_q.size() != 0);
        chk("rsp_valid", rsp_valid, m_rv);
        chk("alu_op", alu_op, m_aop);
        chk("alu_a", alu_a, m_aa);
        chk("alu_b", alu_b, m_ab);
        chk("op_count", op_count, (m_cnt > 65535) ? 65535 : m_cnt);
        chk("sat_count", s_op_count, (m_cnt > 3) ? 3 : m_cnt);
        if (m_q.size() != 0 && m_age >= 2) begin
            e = alu_fn(m_q[0].op, m_q[0].a, m_q[0].b);
            chk("rsp_id", rsp_id, m_q[0].id);
            chk("rsp_res", rsp_res, e[31:0]);
            chk("rsp_flag", rsp_flag, e[32]);
        end
        o_r0 = req0_ready;
        o_r1 = req1_ready;
        ret  = (m_q.size() != 0) && m_age >= 2 && rr;
        acc  = g0 || g1;
        @(posedge clk);
        #1;
        if (ret) begin
            void'(m_q.pop_front());
            m_cnt++;
        end
        if (acc) begin
            t.id = g1;
            t.op = g1 ? op1 : op0;
            t.a  = g1 ? a1 : a0;
            t.b  = g1 ? b1 : b0;
            m_q.push_back(t);
            m_age  = 1;
            m_last = g1;
            m_aop  = t.op;
            m_aa   = t.a;
            m_ab   = t.b;
        end else if (m_q.size() != 0) begin
            m_age++;
        end
        if (ret && !acc) m_rv = 1'b0;
        if (m_q.size() != 0 && m_age >= 2) m_rv = 1'b1;
    endtask

    task automatic idle(input bit rr);
        cyc(0, 5'd0, 0, 0, 0, 5'd0, 0, 0, rr);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req0_valid = 0; req1_valid = 0; rsp_ready = 0;
        req0_op = 0; req0_a = 0; req0_b = 0;
        req1_op = 0; req1_a = 0; req1_b = 0;
        @(posedge clk);
        #1;
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_alu_a", alu_a, 0);
        chk("rst_op_count", op_count, 0);
        chk("rst_rsp_res", rsp_res, 0);
        rst = 1'b0;
        model_reset();
    endtask

    typedef struct {
        bit          port;
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        bit          is_br;
        logic [31:0] res;
        bit          flag;
        logic [1:0]  sat;
    } vec_t;

    vec_t vt[6];

    bit          rv0, rv1, rr;
    logic [4:0]  rop0, rop1;
    logic [31:0] ra0, rb0, ra1, rb1;
    int          gid[$];
    int          gcy[$];

    function automatic logic [4:0] pick_op();
        case ($urandom_range(0, 4))
            0: return 5'b00000;
            1: return 5'b01000;
            2: return 5'b11000;
            3: return 5'b11110;
            default: return 5'($urandom);
        endcase
    endfunction

    initial begin
        model_reset();
        vt[0] = '{0, 5'b00000, 32'd5, 32'd7, 0, 32'd12, 0, 2'd1};
        vt[1] = '{0, 5'b01000, 32'd10, 32'd3, 0, 32'd7, 0, 2'd2};
        vt[2] = '{1, 5'b11000, 32'd3, 32'd3, 1, 32'd0, 1, 2'd3};
        vt[3] = '{1, 5'b11110, 32'd1, 32'hFFFF_FFFF, 1, 32'd0, 1, 2'd3};
        vt[4] = '{0, 5'b00000, 32'hFFFF_FFFF, 32'd1, 0, 32'd0, 0, 2'd3};
        vt[5] = '{1, 5'b11000, 32'd3, 32'd4, 1, 32'd0, 0, 2'd3};

        do_reset();

        // Directed single operations, one at a time.
        for (int i = 0; i < 6; i++) begin
            if (vt[i].port)
                cyc(0, 0, 0, 0, 1, vt[i].op, vt[i].a, vt[i].b, 0);
            else
                cyc(1, vt[i].op, vt[i].a, vt[i].b, 0, 0, 0, 0, 0);
            chk("vec_accept", vt[i].port ? o_r1 : o_r0, 1);
            chk("vec_alu_a", alu_a, vt[i].a);
            idle(0);
            chk("vec_id", rsp_id, vt[i].port);
            if (vt[i].is_br) chk("vec_flag", rsp_flag, vt[i].flag);
            else chk("vec_res", rsp_res, vt[i].res);
            idle(1);
            chk("vec_count", op_count, i + 1);
            chk("vec_sat", s_op_count, vt[i].sat);
        end

        // Tie and fairness with continuous requests.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            cyc(1, 5'b01000, 32'd10, 32'd3, 1, 5'b11000, 32'd3, 32'd3, 1);
            if (o_r0) begin gid.push_back(0); gcy.push_back(i); end
            if (o_r1) begin gid.push_back(1); gcy.push_back(i); end
            if (i % 2 == 1) begin
                chk("fair_id", rsp_id, ((i - 1) / 2) % 2);
                if (((i - 1) / 2) % 2 == 0) chk("fair_res", rsp_res, 7);
                else chk("fair_flag", rsp_flag, 1);
            end
        end
        chk("fair_grants", gid.size(), 4);
        for (int i = 0; i < 4 && i < gid.size(); i++) begin
            chk("fair_order", gid[i], i % 2);
            chk("fair_cycle", gcy[i], 2 * i);
        end

        // Backpressure, then same-cycle acceptance; second op is a branch.
        do_reset();
        cyc(1, 5'b00000, 32'd1, 32'd2, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 5'b11110, 32'd1, 32'hFFFF_FFFF, 0);
        for (int i = 0; i < 5; i++) begin
            cyc(0, 0, 0, 0, 1, 5'b11110, 32'd1, 32'hFFFF_FFFF, 0);
            chk("bp_res", rsp_res, 3);
            chk("bp_id", rsp_id, 0);
            chk("bp_valid", rsp_valid, 1);
            chk("bp_count", op_count, 0);
            chk("bp_ready", o_r1, 0);
        end
        cyc(0, 0, 0, 0, 1, 5'b11110, 32'd1, 32'hFFFF_FFFF, 1);
        chk("bp_same_cycle_acc", o_r1, 1);
        chk("bp_count_after", op_count, 1);
        idle(0);
        chk("br_id", rsp_id, 1);
        chk("br_flag", rsp_flag, 1);
        chk("br_res", rsp_res, 32'hFFFF_FFFE);
        idle(1);

        // Reset asserted while an operation sits in EXEC.
        cyc(1, 5'b00000, 32'd9, 32'd9, 0, 0, 0, 0, 0);
        rst = 1'b1;
        #1;
        chk("mid_rsp_valid", rsp_valid, 0);
        chk("mid_busy", busy, 0);
        chk("mid_alu_a", alu_a, 0);
        chk("mid_op_count", op_count, 0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc(1, 5'b00000, 32'd4, 32'd4, 1, 5'b11000, 32'd4, 32'd4, 1);
        chk("mid_tie_p0", o_r0, 1);
        chk("mid_tie_p1", o_r1, 0);

        // Random traffic; requesters hold requests until accepted.
        rv0 = 0; rv1 = 0; o_r0 = 0; o_r1 = 0;
        rop0 = 0; rop1 = 0; ra0 = 0; rb0 = 0; ra1 = 0; rb1 = 0;
        for (int i = 0; i < 3000; i++) begin
            if (!rv0 || o_r0) begin
                rv0  = ($urandom_range(0, 99) < 60);
                rop0 = pick_op();
                ra0  = $urandom;
                rb0  = ($urandom_range(0, 3) == 0) ? ra0 : $urandom;
            end else if ($urandom_range(0, 99) < 3) begin
                rv0 = 0;
            end
            if (!rv1 || o_r1) begin
                rv1  = ($urandom_range(0, 99) < 60);
                rop1 = pick_op();
                ra1  = $urandom;
                rb1  = ($urandom_range(0, 3) == 0) ? ra1 : $urandom;
            end else if ($urandom_range(0, 99) < 3) begin
                rv1 = 0;
            end
            rr = ($urandom_range(0, 99) < 70);
            cyc(rv0, rop0, ra0, rb0, rv1, rop1, ra1, rb1, rr);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
Shares the single combinational ALU (5-bit operation code, two 32-bit operands, 32-bit result, 1-bit branch flag) between two requesters, such as the execute path (port 0) and the branch/compare path (port 1).
- Arbitrates round-robin and registers the winning operation into the ALU inputs.
- Captures the ALU result and flag one cycle later.
- Returns them to the owner through a valid/ready response channel with backpressure.
- Keeps a saturating count of completed operations.

Parameters:
WIDTH, 32, operand and result width.
OPW, 5, ALU operation code width.
CNTW, 16, width of the completed-operation counter.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst  in  1  asynchronous, active-high reset.
req0_valid  in  1  requester 0 has an operation.
req0_op  in  OPW  requester 0 operation code.
req0_a  in  WIDTH  requester 0 operand A.
req0_b  in  WIDTH  requester 0 operand B.
req0_ready  out  1  requester 0 operation accepted this cycle.
req1_valid, req1_op, req1_a, req1_b, req1_ready  same as port 0, for requester 1.
alu_op  out  OPW  registered operation code driven to the ALU.
alu_a  out  WIDTH  registered operand A driven to the ALU.
alu_b  out  WIDTH  registered operand B driven to the ALU.
alu_res  in  WIDTH  ALU result (combinational from alu_op/a/b).
alu_flag  in  1  ALU comparison flag.
rsp_valid  out  1  response holds a valid result.
rsp_id  out  1  owner of the response (0 or 1).
rsp_res  out  WIDTH  captured result.
rsp_flag  out  1  captured flag.
rsp_ready  in  1  consumer takes the response.
busy  out  1  high in EXEC or RESP.
op_count  out  CNTW  completed responses; saturates at all-ones.

Behaviour:
- Reset (async, while rst=1):
  - state=IDLE.
  - alu_op/alu_a/alu_b=0.
  - rsp_valid=0, rsp_id=0, rsp_res=0, rsp_flag=0.
  - op_count=0.
  - last_grant=1, so port 0 wins the first tie.
- Reset mid-operation discards the in-flight operation and any pending response, with no handshake toward either requester.
- States: IDLE, EXEC, RESP.
- Accept window: the arbiter may accept only when state=IDLE, or when state=RESP and rsp_ready=1 (the response retires in the same cycle).
- Arbitration (combinational, inside the accept window):
  - Only one valid: that port wins.
  - Both valid: the port != last_grant wins.
- reqN_ready=1 only for the winner inside the accept window; 0 at all other times. Never more than one ready in a cycle.
- Acceptance (reqN_valid & reqN_ready) at edge T:
  - alu_op/alu_a/alu_b <= winner's fields.
  - owner <= N; last_grant <= N.
  - state <= EXEC.
- EXEC (one cycle):
  - rsp_res <= alu_res; rsp_flag <= alu_flag; rsp_id <= owner.
  - rsp_valid <= 1; state <= RESP.
- RESP:
  - Outputs are held stable while rsp_ready=0.
  - On rsp_ready=1: op_count increments (holds at 2^CNTW-1).
  - Then either state <= EXEC with rsp_valid kept at 1 for the new operation from the following cycle if a new request was accepted this cycle, or state <= IDLE and rsp_valid <= 0 otherwise.
- Latency: accept at edge T -> rsp_valid=1 in the cycle after edge T+1 (two edges). With rsp_ready held at 1, throughput is one operation per 2 cycles.
- alu_op/a/b hold their last value in IDLE and RESP; they change only on acceptance.
- The operation code is passed through unmodified:
  - Compute codes (top two bits != 11) give a meaningful rsp_res.
  - Branch codes (top two bits == 11) give a meaningful rsp_flag.
  - Both fields are always captured; the owner interprets them.
- Requesters must hold valid and fields stable until ready. A requester dropping valid before acceptance is simply not served.
- busy = (state != IDLE).

Test Plan:
- Single op: reset, then req0 ADD (00000), a=5, b=7 -> req0_ready=1 in the request cycle; alu_op=00000, alu_a=5, alu_b=7 after the edge; two edges after acceptance rsp_valid=1, rsp_id=0, rsp_res=12; op_count=1 after rsp_ready.
- Tie and fairness: both requesters valid continuously (req0 SUB 01000 10-3, req1 EQ 11000 3==3), rsp_ready=1 -> grants alternate 0,1,0,1; responses carry rsp_res=7 for id 0 and rsp_flag=1 for id 1; an accept occurs every 2 cycles.
- Backpressure: rsp_ready=0 for 5 cycles in RESP -> rsp_valid, rsp_res and rsp_id stay stable; both req_ready stay 0; op_count unchanged; after rsp_ready=1, next acceptance occurs in that same cycle.
- Branch flag: req1 LTU (11110), a=1, b=0xFFFFFFFF -> rsp_id=1, rsp_flag equals alu_flag captured in EXEC; rsp_res equals alu_res captured at the same edge.
- Reset mid-operation: assert rst during EXEC -> immediately rsp_valid=0, busy=0, alu_a=0, op_count=0; after release, the first tie goes to port 0.
- Saturation: CNTW=2, complete 5 operations -> op_count reads 1,2,3,3,3.
